mcs_fpro_bridge: RTL and testbench
==================================

Name: mcs_fpro_bridge

Overview:
- Upstream of the MMIO slot wrapper. Converts the MicroBlaze MCS I/O bus into the FPro MMIO bus.
- FPro MMIO bus signals: mmio_cs, mmio_read, mmio_write, 21-bit word address, 32-bit write/read data.
- Each MCS transaction is sequenced as a fixed three-cycle exchange.
- Decodes the bridge address window, returns a fixed pattern for unmapped accesses, and keeps sticky protocol-error flags for firmware diagnostics.

Parameters:
- BRG_BASE, 32'hC000_0000, bridge window base; bits [31:24] are compared.
- UNMAPPED_DATA, 32'hDEAD_BEEF, read data returned for accesses outside the MMIO sub-window.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- io_addr_strobe  input  1  MCS address strobe
- io_read_strobe  input  1  MCS read request (one-cycle pulse)
- io_write_strobe  input  1  MCS write request (one-cycle pulse)
- io_byte_enable  input  4  MCS byte lanes
- io_address  input  32  MCS byte address
- io_write_data  input  32  MCS write data
- io_read_data  output  32  data returned to MCS
- io_ready  output  1  transaction-complete pulse to MCS
- fp_mmio_cs  output  1  FPro chip select
- fp_mmio_read  output  1  FPro read strobe
- fp_mmio_write  output  1  FPro write strobe
- fp_mmio_addr  output  21  FPro word address
- fp_mmio_wr_data  output  32  FPro write data
- fp_mmio_rd_data  input  32  FPro read data (combinational from the slot mux)
- err_clr  input  1  clears all sticky flags
- err_unmapped  output  1  sticky: access outside the MMIO sub-window
- err_partial  output  1  sticky: write with io_byte_enable != 4'b1111
- err_proto  output  1  sticky: strobe while busy, or read and write strobes together

Behaviour:
- Reset: synchronous, active-high. All outputs go to 0 and the FSM returns to IDLE.
  - Reset mid-transaction drops the transaction: no io_ready is issued and no FPro strobe follows.
- Decode, evaluated on the accepted request:
  - hit = (io_address[31:24] == BRG_BASE[31:24]) && (io_address[23] == 0).
  - fp_mmio_addr = io_address[22:2]; io_address[1:0] is ignored.
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE:
  - An accept happens in cycle T when io_read_strobe or io_write_strobe is high. Address, data, byte enables, direction and hit are latched.
  - If both strobes are high, the request is treated as a write and err_proto is set.
  - Next state is ACCESS.
- ACCESS (cycle T+1):
  - If hit: fp_mmio_cs = 1, plus fp_mmio_read or fp_mmio_write, high for exactly this one cycle. fp_mmio_addr and fp_mmio_wr_data are valid this cycle.
  - On a hit read, fp_mmio_rd_data is registered at the end of T+1.
  - If miss: no FPro strobes; err_unmapped is set; read data register is loaded with UNMAPPED_DATA; writes are discarded.
  - Next state is CAPTURE.
- CAPTURE (cycle T+2):
  - io_ready = 1 for exactly one cycle.
  - io_read_data holds the captured value. It is 0 for writes and holds its value until the next read completes.
  - Next state is IDLE. A new strobe may be accepted in the following cycle at the earliest.
- Fixed latency: strobe at T gives io_ready at T+2, for both reads and writes, hit or miss.
- Partial writes: fp_mmio_wr_data = io_write_data with disabled byte lanes forced to 0x00. err_partial is set. The write is still issued.
  - Byte enables are ignored on reads.
- Strobe while in ACCESS or CAPTURE: ignored (no second transaction, no extra io_ready) and err_proto is set.
- io_addr_strobe is not required for acceptance; the read/write strobes alone qualify a request.
- Sticky flags:
  - Set on the cycle of the detecting event and held until err_clr or reset.
  - If err_clr and a set event occur in the same cycle, set wins.
- Only registered values drive the fp_mmio_* outputs; no combinational path from io_* to fp_mmio_*.

Test Plan:
- Hit read: strobe read at 0xC000_0104 at T; fp_mmio_rd_data = 0x1234_5678 -> at T+1 fp_mmio_cs = 1, fp_mmio_read = 1, fp_mmio_addr = 0x41; at T+2 io_ready = 1 and io_read_data = 0x1234_5678; no error flags set.
- Hit write with full enables: write 0xA5A5_0F0F to 0xC000_0008 -> at T+1 fp_mmio_write = 1, fp_mmio_addr = 0x2, fp_mmio_wr_data = 0xA5A5_0F0F; io_ready at T+2.
- Partial write: byte_enable = 4'b0011, data 0xFFFF_FFFF -> fp_mmio_wr_data = 0x0000_FFFF and err_partial = 1. Then err_clr -> err_partial = 0.
- Unmapped read at 0xC080_0000, and read at 0x4000_0000 -> no fp_mmio_cs; io_ready at T+2 with io_read_data = 0xDEAD_BEEF; err_unmapped = 1.
- Protocol errors:
  - Second strobe at T+1 -> exactly one io_ready, one FPro access, err_proto = 1.
  - Read and write strobes together -> write performed, err_proto = 1.
- Reset asserted at T+1 of a read -> no io_ready, all outputs 0 the next cycle; a fresh read afterwards completes normally at T'+2.

Source files
------------

// File: rtl/mcs_fpro_bridge.sv
// MicroBlaze MCS I/O bus to FPro MMIO bus bridge.
// Each request runs a fixed three-cycle exchange. Sticky flags record protocol faults.
module mcs_fpro_bridge #(
    parameter logic [31:0] BRG_BASE      = 32'hC000_0000,
    parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        fp_mmio_cs,
    output logic        fp_mmio_read,
    output logic        fp_mmio_write,
    output logic [20:0] fp_mmio_addr,
    output logic [31:0] fp_mmio_wr_data,
    input  logic [31:0] fp_mmio_rd_data,
    input  logic        err_clr,
    output logic        err_unmapped,
    output logic        err_partial,
    output logic        err_proto
);

    typedef enum logic [1:0] {StIdle, StAccess, StCapture} state_e;

    state_e      state_q;
    logic        is_write_q, hit_q;
    logic        cs_q, rd_q, wr_q, ready_q;
    logic [20:0] addr_q;
    logic [31:0] wdata_q, rdata_q;
    logic        err_unmapped_q, err_partial_q, err_proto_q;
    logic        err_unmapped_d, err_partial_d, err_proto_d;

    logic        req, idle, accept, hit;
    logic        set_unmapped, set_partial, set_proto;
    logic [31:0] lane_mask;
    logic        unused_inputs;

    // Address strobe and byte offset play no part in qualifying or decoding a request.
    assign unused_inputs = ^{io_addr_strobe, io_address[1:0]};

    always_comb begin
        req          = io_read_strobe | io_write_strobe;
        idle         = (state_q == StIdle);
        accept       = idle & req;
        hit          = (io_address[31:24] == BRG_BASE[31:24]) & ~io_address[23];
        lane_mask    = {{8{io_byte_enable[3]}}, {8{io_byte_enable[2]}},
                        {8{io_byte_enable[1]}}, {8{io_byte_enable[0]}}};
        set_proto    = (accept & io_read_strobe & io_write_strobe) | (~idle & req);
        set_partial  = accept & io_write_strobe & (io_byte_enable != 4'hF);
        set_unmapped = (state_q == StAccess) & ~hit_q;
        // A set event in the same cycle as err_clr takes priority.
        err_unmapped_d = (err_unmapped_q & ~err_clr) | set_unmapped;
        err_partial_d  = (err_partial_q & ~err_clr) | set_partial;
        err_proto_d    = (err_proto_q & ~err_clr) | set_proto;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            is_write_q     <= 1'b0;
            hit_q          <= 1'b0;
            cs_q           <= 1'b0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            ready_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            err_unmapped_q <= 1'b0;
            err_partial_q  <= 1'b0;
            err_proto_q    <= 1'b0;
        end else begin
            cs_q           <= 1'b0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            ready_q        <= 1'b0;
            err_unmapped_q <= err_unmapped_d;
            err_partial_q  <= err_partial_d;
            err_proto_q    <= err_proto_d;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        is_write_q <= io_write_strobe;
                        hit_q      <= hit;
                        addr_q     <= io_address[22:2];
                        wdata_q    <= io_write_data & lane_mask;
                        cs_q       <= hit;
                        rd_q       <= hit & ~io_write_strobe;
                        wr_q       <= hit & io_write_strobe;
                        state_q    <= StAccess;
                    end
                end
                StAccess: begin
                    if (is_write_q) begin
                        rdata_q <= '0;
                    end else if (hit_q) begin
                        rdata_q <= fp_mmio_rd_data;
                    end else begin
                        rdata_q <= UNMAPPED_DATA;
                    end
                    ready_q <= 1'b1;
                    state_q <= StCapture;
                end
                StCapture: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    assign io_read_data    = rdata_q;
    assign io_ready        = ready_q;
    assign fp_mmio_cs      = cs_q;
    assign fp_mmio_read    = rd_q;
    assign fp_mmio_write   = wr_q;
    assign fp_mmio_addr    = addr_q;
    assign fp_mmio_wr_data = wdata_q;
    assign err_unmapped    = err_unmapped_q;
    assign err_partial     = err_partial_q;
    assign err_proto       = err_proto_q;

endmodule

// File: tb/tb_mcs_fpro_bridge.sv
// Bench for mcs_fpro_bridge: transaction-level reference model, directed cases and random traffic.
module tb_mcs_fpro_bridge;

    localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_addr_strobe = 1'b0;
    logic        io_read_strobe = 1'b0;
    logic        io_write_strobe = 1'b0;
    logic [3:0]  io_byte_enable = 4'hF;
    logic [31:0] io_address = '0;
    logic [31:0] io_write_data = '0;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic        fp_mmio_cs, fp_mmio_read, fp_mmio_write;
    logic [20:0] fp_mmio_addr;
    logic [31:0] fp_mmio_wr_data;
    logic [31:0] fp_mmio_rd_data = '0;
    logic        err_clr = 1'b0;
    logic        err_unmapped, err_partial, err_proto;

    always #5 clk = ~clk;

    mcs_fpro_bridge dut (
        .clk             (clk),
        .reset           (reset),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .fp_mmio_cs      (fp_mmio_cs),
        .fp_mmio_read    (fp_mmio_read),
        .fp_mmio_write   (fp_mmio_write),
        .fp_mmio_addr    (fp_mmio_addr),
        .fp_mmio_wr_data (fp_mmio_wr_data),
        .fp_mmio_rd_data (fp_mmio_rd_data),
        .err_clr         (err_clr),
        .err_unmapped    (err_unmapped),
        .err_partial     (err_partial),
        .err_proto       (err_proto)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: one outstanding transaction described by its accept cycle.
    int          cyc = 0;
    bit          known = 0, after_reset = 0, busy = 0;
    int          t_acc = 0;
    bit          m_wr = 0, m_hit = 0;
    logic [20:0] m_addr = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;
    bit          m_unm = 0, m_par = 0, m_pro = 0;

    bit          chk_en = 0;
    bit          e_cs, e_rd, e_wr, e_ready, e_zero, e_unm, e_par, e_pro;
    logic [20:0] e_addr;
    logic [31:0] e_wdata, e_rdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >= 32'hC000_0000) && (a < 32'hC080_0000);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("io_ready", 32'(io_ready), 32'(e_ready));
            chk("fp_mmio_cs", 32'(fp_mmio_cs), 32'(e_cs));
            chk("fp_mmio_read", 32'(fp_mmio_read), 32'(e_rd));
            chk("fp_mmio_write", 32'(fp_mmio_write), 32'(e_wr));
            chk("io_read_data", io_read_data, e_rdata);
            chk("err_unmapped", 32'(err_unmapped), 32'(e_unm));
            chk("err_partial", 32'(err_partial), 32'(e_par));
            chk("err_proto", 32'(err_proto), 32'(e_pro));
            if (e_cs) chk("fp_mmio_addr", 32'(fp_mmio_addr), 32'(e_addr));
            if (e_wr) chk("fp_mmio_wr_data", fp_mmio_wr_data, e_wdata);
            if (e_zero) begin
                chk("addr_after_reset", 32'(fp_mmio_addr), 32'h0);
                chk("wdata_after_reset", fp_mmio_wr_data, 32'h0);
            end
        end
    end

    // One clock cycle: publish expectations for this cycle, drive inputs, advance the model.
    task automatic step(input bit rs, input bit ws, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] frd, input bit clr,
                        input bit rst);
        bit s_unm, s_par, s_pro;
        @(posedge clk);
        #1;
        cyc++;
        chk_en  = known;
        e_cs    = busy && (cyc == t_acc + 1) && m_hit;
        e_rd    = e_cs && !m_wr;
        e_wr    = e_cs && m_wr;
        e_ready = busy && (cyc == t_acc + 2);
        e_addr  = m_addr;
        e_wdata = m_wdata;
        e_rdata = m_rdata;
        e_unm   = m_unm;
        e_par   = m_par;
        e_pro   = m_pro;
        e_zero  = after_reset;
        after_reset = 0;

        reset           = rst;
        io_read_strobe  = rs;
        io_write_strobe = ws;
        io_addr_strobe  = rs | ws;
        io_address      = a;
        io_write_data   = wd;
        io_byte_enable  = be;
        fp_mmio_rd_data = frd;
        err_clr         = clr;

        s_unm = 0;
        s_par = 0;
        s_pro = 0;
        if (rst) begin
            known = 1;
            after_reset = 1;
            busy = 0;
            m_rdata = '0;
            m_unm = 0;
            m_par = 0;
            m_pro = 0;
        end else begin
            if (busy) begin
                if (rs || ws) s_pro = 1;
                if (cyc == t_acc + 1) begin
                    if (!m_hit) s_unm = 1;
                    m_rdata = m_wr ? 32'h0 : (m_hit ? frd : UNMAPPED);
                end
                if (cyc == t_acc + 2) busy = 0;
            end else if (rs || ws) begin
                busy   = 1;
                t_acc  = cyc;
                m_wr   = ws;
                m_hit  = in_window(a);
                m_addr = 21'(a >> 2);
                for (int b = 0; b < 4; b++)
                    m_wdata[8*b +: 8] = be[b] ? wd[8*b +: 8] : 8'h00;
                if (rs && ws) s_pro = 1;
                if (ws && be != 4'hF) s_par = 1;
            end
            m_unm = (m_unm && !clr) || s_unm;
            m_par = (m_par && !clr) || s_par;
            m_pro = (m_pro && !clr) || s_pro;
        end
    endtask

    task automatic idle(input bit clr);
        step(0, 0, 32'h0, 32'h0, 4'hF, $urandom, clr, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 4'hF, 0, 0, 1);
        step(0, 0, 0, 0, 4'hF, 0, 0, 1);
        idle(0);
        chk("reset_ready", 32'(io_ready), 32'h0);
        chk("reset_rdata", io_read_data, 32'h0);

        // Hit read
        step(1, 0, 32'hC000_0104, 0, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, 4'hF, 32'h1234_5678, 0, 0);
        chk("hit_rd_cs", 32'(fp_mmio_cs), 32'h1);
        chk("hit_rd_strobe", 32'(fp_mmio_read), 32'h1);
        chk("hit_rd_addr", 32'(fp_mmio_addr), 32'h41);
        idle(0);
        chk("hit_rd_ready", 32'(io_ready), 32'h1);
        chk("hit_rd_data", io_read_data, 32'h1234_5678);
        chk("hit_rd_flags", 32'({err_unmapped, err_partial, err_proto}), 32'h0);

        // Hit write, full lanes
        step(0, 1, 32'hC000_0008, 32'hA5A5_0F0F, 4'hF, 0, 0, 0);
        idle(0);
        chk("hit_wr_strobe", 32'(fp_mmio_write), 32'h1);
        chk("hit_wr_addr", 32'(fp_mmio_addr), 32'h2);
        chk("hit_wr_data", fp_mmio_wr_data, 32'hA5A5_0F0F);
        idle(0);
        chk("hit_wr_ready", 32'(io_ready), 32'h1);
        chk("hit_wr_rdata", io_read_data, 32'h0);

        // Partial write, then clear
        step(0, 1, 32'hC000_0010, 32'hFFFF_FFFF, 4'b0011, 0, 0, 0);
        idle(0);
        chk("part_wr_data", fp_mmio_wr_data, 32'h0000_FFFF);
        chk("part_flag_set", 32'(err_partial), 32'h1);
        idle(0);
        idle(1);
        idle(0);
        chk("part_flag_clr", 32'(err_partial), 32'h0);

        // Unmapped reads
        step(1, 0, 32'hC080_0000, 0, 4'hF, 0, 0, 0);
        idle(0);
        chk("unm1_cs", 32'(fp_mmio_cs), 32'h0);
        idle(0);
        chk("unm1_ready", 32'(io_ready), 32'h1);
        chk("unm1_data", io_read_data, 32'hDEAD_BEEF);
        chk("unm1_flag", 32'(err_unmapped), 32'h1);
        step(1, 0, 32'h4000_0000, 0, 4'hF, 0, 0, 0);
        idle(0);
        chk("unm2_cs", 32'(fp_mmio_cs), 32'h0);
        idle(0);
        chk("unm2_data", io_read_data, 32'hDEAD_BEEF);
        idle(1);
        idle(0);

        // Strobe while busy
        step(1, 0, 32'hC000_0020, 0, 4'hF, 0, 0, 0);
        step(1, 0, 32'hC000_0040, 0, 4'hF, 32'h0BAD_F00D, 0, 0);
        idle(0);
        chk("busy_ready", 32'(io_ready), 32'h1);
        chk("busy_proto", 32'(err_proto), 32'h1);
        idle(0);
        chk("busy_no_extra", 32'(io_ready), 32'h0);
        idle(1);

        // Read and write strobes together
        step(1, 1, 32'hC000_0030, 32'h1122_3344, 4'hF, 0, 0, 0);
        idle(0);
        chk("both_write", 32'(fp_mmio_write), 32'h1);
        chk("both_read", 32'(fp_mmio_read), 32'h0);
        chk("both_proto", 32'(err_proto), 32'h1);
        idle(0);
        idle(0);

        // Reset during a read, then a fresh read
        step(1, 0, 32'hC000_0050, 0, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, 4'hF, 32'h5555_AAAA, 0, 1);
        idle(0);
        chk("rst_mid_ready", 32'(io_ready), 32'h0);
        chk("rst_mid_cs", 32'(fp_mmio_cs), 32'h0);
        idle(0);
        step(1, 0, 32'hC000_0060, 0, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, 4'hF, 32'hCAFE_F00D, 0, 0);
        idle(0);
        chk("rst_fresh_ready", 32'(io_ready), 32'h1);
        chk("rst_fresh_data", io_read_data, 32'hCAFE_F00D);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            logic [3:0]  be;
            int unsigned sel;
            sel = $urandom_range(0, 3);
            a = $urandom;
            if (sel < 2) a[31:23] = 9'b1100_0000_0;
            else if (sel == 2) a[31:23] = 9'b1100_0000_1;
            be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, a, $urandom, be,
                 $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0);
        end
        idle(0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
